// File: rtl/kaipokrandt_fsm_movx.sv
// Register-transfer sequencer: MOV, SWAP (via temp) and wrapping block MOVN with bus-settle cycles.
// Define KAIPOKRANDT_MOVX_SWAP_EN to compile in SWAP mode and the temp-register strobes.
module kaipokrandt_fsm_movx #(
    parameter int unsigned NREG   = 8,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned SETTLE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dec_mov,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] src_sel,
    input  logic [SEL_W-1:0] dst_sel,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NREG-1:0]  src_reg_en,
    output logic [NREG-1:0]  dst_reg_ld,
    output logic             tmp_en,
    output logic             tmp_ld
);

`ifdef KAIPOKRANDT_MOVX_SWAP_EN
    localparam bit SwapEn = 1'b1;
`else
    localparam bit SwapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StDrive, StXfer, StDone} state_e;

    localparam logic [1:0]       ModeSwap   = 2'b01;
    localparam logic [1:0]       ModeMovn   = 2'b10;
    localparam logic [1:0]       ModeIll    = 2'b11;
    localparam logic [SEL_W-1:0] LastIdx    = SEL_W'(NREG - 1);
    localparam logic [SEL_W:0]   NregW      = (SEL_W + 1)'(NREG);
    localparam logic [3:0]       SettleLast = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_e           FirstState = (SETTLE > 0) ? StDrive : StXfer;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [SEL_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [CNT_W-1:0] step_q, step_d, last_q, last_d;
    logic [3:0]       settle_q, settle_d;
    logic             err_q, err_d;
    logic             cap_err, cap_zero;

    logic             load, src_on, dst_on;
    logic [SEL_W-1:0] src_idx, dst_idx;

    // Indices wrap at NREG-1, not at the power of two, so non-power-of-two files work.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + SEL_W'(1);
    endfunction

    always_comb begin
        cap_err  = (mode == ModeIll) || ({1'b0, src_sel} >= NregW) || ({1'b0, dst_sel} >= NregW)
                   || (!SwapEn && mode == ModeSwap);
        cap_zero = (mode == ModeMovn && count == '0) ||
                   (SwapEn && mode == ModeSwap && src_sel == dst_sel);
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        step_d   = step_q;
        last_d   = last_q;
        settle_d = settle_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (start && dec_mov) begin
                    mode_d   = mode;
                    src_d    = src_sel;
                    dst_d    = dst_sel;
                    step_d   = '0;
                    settle_d = '0;
                    err_d    = cap_err;
                    if (mode == ModeSwap)      last_d = CNT_W'(2);
                    else if (mode == ModeMovn) last_d = count - CNT_W'(1);
                    else                       last_d = '0;
                    state_d = (cap_err || cap_zero) ? StDone : FirstState;
                end
            end
            StDrive: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SettleLast) begin
                    settle_d = '0;
                    state_d  = StXfer;
                end
            end
            StXfer: begin
                if (step_q == last_q) begin
                    state_d = StDone;
                end else begin
                    step_d = step_q + CNT_W'(1);
                    if (mode_q == ModeMovn) begin
                        src_d = wrap_inc(src_q);
                        dst_d = wrap_inc(dst_q);
                    end
                    state_d = FirstState;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            mode_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            step_q   <= '0;
            last_q   <= '0;
            settle_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            step_q   <= step_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        busy    = (state_q == StDrive) || (state_q == StXfer);
        done    = (state_q == StDone);
        err     = done && err_q;
        load    = (state_q == StXfer);
        src_on  = 1'b0;
        dst_on  = 1'b0;
        src_idx = src_q;
        dst_idx = dst_q;
        tmp_en  = 1'b0;
        tmp_ld  = 1'b0;
        if (busy) begin
            if (SwapEn && mode_q == ModeSwap) begin
                // Swap steps: src->tmp, dst->src, tmp->dst.
                if (step_q == CNT_W'(0)) begin
                    src_on = 1'b1;
                    tmp_ld = load;
                end else if (step_q == CNT_W'(1)) begin
                    src_idx = dst_q;
                    src_on  = 1'b1;
                    dst_idx = src_q;
                    dst_on  = load;
                end else begin
                    tmp_en = 1'b1;
                    dst_on = load;
                end
            end else begin
                src_on = 1'b1;
                dst_on = load;
            end
        end
        for (int unsigned i = 0; i < NREG; i++) begin
            src_reg_en[i] = src_on && (src_idx == SEL_W'(i));
            dst_reg_ld[i] = dst_on && (dst_idx == SEL_W'(i));
        end
    end

endmodule
